// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//   Responder end of the processor interrupt handshake (INT_IRQ / INT_IACK /
//   INT_IEND). Rising edges on three peripheral request lines are latched as
//   pending events. The lowest-numbered pending source wins, and its 2-bit
//   code is presented to the processor. Only one interrupt is in flight at a
//   time: IDLE -> REQ (code shown) -> SERVICE (busy) -> IDLE.
//
// Parameters
//   CNT_W           width of the acknowledge-timeout counter
//   TIMEOUT_CYCLES  cycles INT_IRQ may be held without INT_IACK
//
// Ports
//   CLK          in   1  clock, all logic on posedge
//   RESET        in   1  synchronous, active-high reset
//   SRC_REQ      in   3  peripheral request levels, bit0 highest priority
//   INT_IRQ      out  2  0 = none, 1/2/3 = source 0/1/2 requesting
//   INT_IACK     in   1  processor acknowledge pulse
//   INT_IEND     in   1  processor end-of-service pulse
//   INT_BUSY     out  1  interrupt in service (between IACK and IEND)
//   INT_PENDING  out  3  latched, unacknowledged events
//   INT_OVERRUN  out  3  sticky, an event was lost on that source
//   INT_TIMEOUT  out  1  pulse on acknowledge timeout
//
// Build option
//   INTC_TIMEOUT_EN  when defined, REQ is abandoned after TIMEOUT_CYCLES
//                    cycles without INT_IACK and INT_TIMEOUT pulses. The
//                    event stays pending and is re-arbitrated. When it is
//                    undefined, REQ waits indefinitely and INT_TIMEOUT is 0.
// ---------------------------------------------------------------------------
module interrupt_controller #(
   parameter int unsigned        CNT_W          = 16,
   parameter logic [CNT_W-1:0]   TIMEOUT_CYCLES = 16'd1024
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [2:0] SRC_REQ,
   output logic [1:0] INT_IRQ,
   input  logic       INT_IACK,
   input  logic       INT_IEND,
   output logic       INT_BUSY,
   output logic [2:0] INT_PENDING,
   output logic [2:0] INT_OVERRUN,
   output logic       INT_TIMEOUT
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [1:0] cur;
   logic [1:0] cur_nxt;
   logic [2:0] src_q;
   logic [2:0] rise;
   logic [2:0] clr;
   logic [2:0] pending;
   logic [2:0] pending_nxt;
   logic [2:0] overrun;
   logic [2:0] overrun_nxt;
   logic       timeout_hit;

   // Fixed priority: lowest set bit wins. Callers only use it with p != 0.
   function automatic logic [1:0] pick_winner(input logic [2:0] p);
      logic [1:0] idx;
      if (p[0]) begin
         idx = 2'd0;
      end else if (p[1]) begin
         idx = 2'd1;
      end else begin
         idx = 2'd2;
      end
      return idx;
   endfunction

`ifdef INTC_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_CYCLES - CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   assign timeout_hit = (cnt == CNT_LAST);

   // Acknowledge-timeout counter and its one-cycle timeout pulse.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt         <= {CNT_W{1'b0}};
         INT_TIMEOUT <= 1'b0;
      end else begin
         if (state != ST_REQ) begin
            // Holds zero outside REQ, so every REQ entry starts from 0.
            cnt <= {CNT_W{1'b0}};
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         INT_TIMEOUT <= (state == ST_REQ) && !INT_IACK && timeout_hit;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg  = ^TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
   assign INT_TIMEOUT = 1'b0;
`endif

   // Edge detection, pending/overrun update and handshake FSM next state.
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      clr       = 3'b000;
      case (state)
         ST_IDLE: begin
            if (pending != 3'b000) begin
               state_nxt = ST_REQ;
               cur_nxt   = pick_winner(pending);
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            // The latched code is not preempted; IEND is ignored here.
            if (INT_IACK) begin
               clr       = 3'b001 << cur;
               state_nxt = ST_SERVICE;
            end else if (timeout_hit) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_REQ;
            end
         end
         ST_SERVICE: begin
            if (INT_IEND) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_SERVICE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cur_nxt   = 2'd0;
         end
      endcase
      rise        = SRC_REQ & ~src_q;
      // A new edge in the same cycle as the acknowledge clear wins, without
      // counting as an overrun.
      pending_nxt = (pending & ~clr) | rise;
      overrun_nxt = overrun | (rise & pending & ~clr);
   end

   // Edge register: loads during reset too, so a held line makes no event.
   always_ff @(posedge CLK) begin
      src_q <= SRC_REQ;
   end

   // FSM state, event flags and registered handshake outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= ST_IDLE;
         cur      <= 2'd0;
         pending  <= 3'b000;
         overrun  <= 3'b000;
         INT_IRQ  <= 2'd0;
         INT_BUSY <= 1'b0;
      end else begin
         state    <= state_nxt;
         cur      <= cur_nxt;
         pending  <= pending_nxt;
         overrun  <= overrun_nxt;
         INT_IRQ  <= (state_nxt == ST_REQ) ? (cur_nxt + 2'd1) : 2'd0;
         INT_BUSY <= (state_nxt == ST_SERVICE);
      end
   end

   assign INT_PENDING = pending;
   assign INT_OVERRUN = overrun;

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//   Directed stimulus with hand-computed expectations. The stimulus pushes
//   the expected output snapshot together with the cycle at which it must
//   be seen. A separate monitor samples the outputs 1 time unit after every
//   posedge and compares them against the queued entries for that cycle.
//   Snapshot layout: {IRQ[1:0], BUSY, PENDING[2:0], OVERRUN[2:0], TIMEOUT}.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] src_req;
   logic [1:0] int_irq;
   logic       int_iack;
   logic       int_iend;
   logic       int_busy;
   logic [2:0] int_pending;
   logic [2:0] int_overrun;
   logic       int_timeout;

   typedef struct {
      int         cyc;
      logic [9:0] val;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 1'b0;

   interrupt_controller #(
      .CNT_W          (16),
      .TIMEOUT_CYCLES (16'd8)
   ) dut (
      .CLK         (clk),
      .RESET       (reset),
      .SRC_REQ     (src_req),
      .INT_IRQ     (int_irq),
      .INT_IACK    (int_iack),
      .INT_IEND    (int_iend),
      .INT_BUSY    (int_busy),
      .INT_PENDING (int_pending),
      .INT_OVERRUN (int_overrun),
      .INT_TIMEOUT (int_timeout)
   );

   always #5 clk = ~clk;

   // Queue an expected snapshot n clock edges from now.
   task automatic expect_out(input int n, input logic [1:0] irq, input logic busy,
                             input logic [2:0] pend, input logic [2:0] ovr,
                             input logic to, input string name);
      exp_t e;
      e.cyc  = cyc + n;
      e.val  = {irq, busy, pend, ovr, to};
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: compare every queued entry that is due at this sample point.
   initial begin
      logic [9:0] act;
      forever begin
         @(posedge clk);
         #1;
         cyc = cyc + 1;
         act = {int_irq, int_busy, int_pending, int_overrun, int_timeout};
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
               checks = checks + 1;
               if (sb[i].cyc < cyc || act !== sb[i].val) begin
                  failures = failures + 1;
                  $display("FAIL %s cyc=%0d got irq=%0d busy=%0b pend=%b ovr=%b to=%0b want irq=%0d busy=%0b pend=%b ovr=%b to=%0b",
                           sb[i].name, cyc, act[9:8], act[7], act[6:4], act[3:1], act[0],
                           sb[i].val[9:8], sb[i].val[7], sb[i].val[6:4], sb[i].val[3:1], sb[i].val[0]);
               end
               sb.delete(i);
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      if (!done) begin
         $display("FAIL watchdog simulation did not complete");
         $fatal(1, "watchdog");
      end
   end

   initial begin
      reset    = 1'b1;
      src_req  = 3'b000;
      int_iack = 1'b0;
      int_iend = 1'b0;
      tick();
      expect_out(1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, "in_reset");
      tick();
      tick();
      reset = 1'b0;
      expect_out(1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, "after_reset");
      tick();

      // 1: single source 1, IACK ignored while in service.
      src_req = 3'b010;
      expect_out(1, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, "t1_pending");
      expect_out(2, 2'd2, 1'b0, 3'b010, 3'b000, 1'b0, "t1_irq2");
      tick(); tick();
      src_req  = 3'b000;
      int_iack = 1'b1;
      expect_out(1, 2'd0, 1'b1, 3'b000, 3'b000, 1'b0, "t1_iack");
      tick();
      expect_out(1, 2'd0, 1'b1, 3'b000, 3'b000, 1'b0, "t1_iack_ignored");
      tick();
      int_iack = 1'b0;
      int_iend = 1'b1;
      expect_out(1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, "t1_iend");
      tick();
      int_iend = 1'b0;

      // 2: sources 0 and 2 together; second IACK arrives with IEND.
      src_req = 3'b101;
      expect_out(1, 2'd0, 1'b0, 3'b101, 3'b000, 1'b0, "t2_pending");
      expect_out(2, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, "t2_irq1");
      tick(); tick();
      src_req  = 3'b000;
      int_iack = 1'b1;
      expect_out(1, 2'd0, 1'b1, 3'b100, 3'b000, 1'b0, "t2_iack1");
      tick();
      int_iack = 1'b0;
      int_iend = 1'b1;
      expect_out(1, 2'd0, 1'b0, 3'b100, 3'b000, 1'b0, "t2_idle_gap");
      expect_out(2, 2'd3, 1'b0, 3'b100, 3'b000, 1'b0, "t2_irq3");
      tick();
      int_iend = 1'b0;
      tick();
      int_iack = 1'b1;
      int_iend = 1'b1;
      expect_out(1, 2'd0, 1'b1, 3'b000, 3'b000, 1'b0, "t2_iack_iend_together");
      tick();
      int_iack = 1'b0;
      expect_out(1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, "t2_done");
      tick();
      int_iend = 1'b0;

      // 3: no preemption; IEND ignored in REQ.
      src_req = 3'b100;
      expect_out(2, 2'd3, 1'b0, 3'b100, 3'b000, 1'b0, "t3_irq3");
      tick(); tick();
      src_req  = 3'b101;
      int_iend = 1'b1;
      expect_out(1, 2'd3, 1'b0, 3'b101, 3'b000, 1'b0, "t3_no_preempt");
      tick();
      int_iend = 1'b0;
      expect_out(1, 2'd3, 1'b0, 3'b101, 3'b000, 1'b0, "t3_hold");
      tick();
      int_iack = 1'b1;
      expect_out(1, 2'd0, 1'b1, 3'b001, 3'b000, 1'b0, "t3_iack");
      tick();
      int_iack = 1'b0;
      int_iend = 1'b1;
      expect_out(2, 2'd1, 1'b0, 3'b001, 3'b000, 1'b0, "t3_irq1");
      tick();
      int_iend = 1'b0;
      tick();
      int_iack = 1'b1;
      tick();
      int_iack = 1'b0;
      int_iend = 1'b1;
      src_req  = 3'b000;
      expect_out(1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, "t3_done");
      tick();
      int_iend = 1'b0;

      // 4: two src1 edges before IACK give overrun and one service.
      src_req = 3'b010;
      tick();
      src_req = 3'b000;
      expect_out(1, 2'd2, 1'b0, 3'b010, 3'b000, 1'b0, "t4_irq2");
      tick();
      src_req = 3'b010;
      expect_out(1, 2'd2, 1'b0, 3'b010, 3'b010, 1'b0, "t4_overrun");
      tick();
      int_iack = 1'b1;
      expect_out(1, 2'd0, 1'b1, 3'b000, 3'b010, 1'b0, "t4_iack");
      tick();
      int_iack = 1'b0;
      int_iend = 1'b1;
      expect_out(2, 2'd0, 1'b0, 3'b000, 3'b010, 1'b0, "t4_single_service");
      expect_out(3, 2'd0, 1'b0, 3'b000, 3'b010, 1'b0, "t4_overrun_sticky");
      tick();
      int_iend = 1'b0;
      tick(); tick();

      // Edge on src2 in the same cycle as its IACK clear: stays pending.
      src_req = 3'b100;
      expect_out(2, 2'd3, 1'b0, 3'b100, 3'b010, 1'b0, "t4b_irq3");
      tick(); tick();
      src_req = 3'b000;
      tick();
      src_req  = 3'b100;
      int_iack = 1'b1;
      expect_out(1, 2'd0, 1'b1, 3'b100, 3'b010, 1'b0, "t4b_set_wins");
      tick();
      int_iack = 1'b0;
      int_iend = 1'b1;
      expect_out(2, 2'd3, 1'b0, 3'b100, 3'b010, 1'b0, "t4b_rearb");
      tick();
      int_iend = 1'b0;
      tick();
      int_iack = 1'b1;
      tick();
      int_iack = 1'b0;
      int_iend = 1'b1;
      src_req  = 3'b000;
      tick();
      int_iend = 1'b0;

      // 5: reset during service with src0 held high.
      src_req = 3'b001;
      expect_out(2, 2'd1, 1'b0, 3'b001, 3'b010, 1'b0, "t5_irq1");
      tick(); tick();
      int_iack = 1'b1;
      expect_out(1, 2'd0, 1'b1, 3'b000, 3'b010, 1'b0, "t5_busy");
      tick();
      int_iack = 1'b0;
      reset    = 1'b1;
      expect_out(1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, "t5_reset");
      tick(); tick();
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         expect_out(i, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, "t5_no_event");
      end
      tick(); tick(); tick(); tick();
      src_req = 3'b000;
      tick();

`ifdef INTC_TIMEOUT_EN
      // 6: no IACK, IRQ held 8 cycles, timeout pulse, one idle cycle, retry.
      src_req = 3'b001;
      for (int i = 2; i <= 9; i++) begin
         expect_out(i, 2'd1, 1'b0, 3'b001, 3'b000, 1'b0, "t6_irq_held");
      end
      expect_out(10, 2'd0, 1'b0, 3'b001, 3'b000, 1'b1, "t6_timeout");
      expect_out(11, 2'd1, 1'b0, 3'b001, 3'b000, 1'b0, "t6_retry");
      for (int i = 0; i < 11; i++) begin
         tick();
      end
      int_iack = 1'b1;
      tick();
      int_iack = 1'b0;
      int_iend = 1'b1;
      src_req  = 3'b000;
      expect_out(1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, "t6_done");
      tick();
      int_iend = 1'b0;
`endif

      tick(); tick();
      for (int i = 0; i < sb.size(); i++) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL %s never sampled due_cyc=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
      end
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
